req_priority_arbiter: RTL and testbench
=======================================

# req_priority_arbiter

Sequential request collector and fixed-priority grant stage for 8 requesters. Latches single-cycle request pulses into a pending register, selects the highest-index unmasked pending request (bit 7 highest, bit 0 lowest), and offers it downstream as a registered index plus a one-hot code on a valid/ready handshake. The pending bit clears on acceptance. It sits upstream of the combinational priority select and turns it into a flow-controlled request queue for interrupt- or command-style sources.

## Interface
- N, 8, number of requesters; fixed at 8 in this revision
- IW, 3, index width, $clog2(N)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; samples on the rising edge of clk
- req  in  N  request pulses; bit i high for one or more cycles sets pending[i]
- mask  in  N  enable per requester; 1 = eligible for grant, 0 = held pending but not granted
- ready  in  1  downstream accepts the current grant when high together with valid
- valid  out  1  grant offered
- idx  out  IW  index of the granted requester; meaningful only while valid=1
- onehot  out  N  one-hot of idx; 0 when valid=0
- pending  out  N  current pending register, for status
- ovf  out  1  sticky: a request arrived for an already-pending bit
- ovf_clr  in  1  clears ovf

## Operation
- pending update each cycle: pending <= (pending & ~acc_clr) | req, where acc_clr = onehot when valid & ready, else 0.
- Eligible set: elig = pending & mask. Select the highest set bit of elig.
- FSM with two states:
  - IDLE: valid=0, onehot=0. If elig != 0, register sel_idx into idx and its one-hot into onehot, then go to OFFER. Otherwise stay in IDLE.
  - OFFER: valid=1. idx and onehot are held stable. On valid & ready, clear that pending bit and return to IDLE. Otherwise stay in OFFER.
- No preemption: a higher-priority request, or a mask change, arriving during OFFER does not alter the offered grant.
- Masking a bit during OFFER does not retract the grant.
- Selection in IDLE uses the registered pending value, so a req pulse is visible only from the cycle after it is sampled.
- Request on the bit being accepted in the same cycle: set wins, so pending[i] stays 1. This is not an overflow.
- ovf set condition: req[i] & pending[i] & ~acc_clr[i] for any i.
- ovf clears on ovf_clr. If set and clear occur in the same cycle, set wins.
- Multiple simultaneous req bits are all latched. They are granted one at a time, highest index first.

## Timing
- Reset values: pending=0, valid=0, idx=0, onehot=0, ovf=0, FSM=IDLE.
- Reset asserted mid-OFFER drops the grant and all pending bits on the next edge. No acceptance is recorded.
- Latency from req sampled at edge t: pending set after t; valid=1 after edge t+1 (2 cycles), if the bit is eligible and the FSM is IDLE.
- Accept at edge t: valid=0 after t. The next grant, if any is eligible, has valid=1 after t+1. This gives exactly one bubble cycle between grants, so peak throughput is 1 grant per 2 cycles.
- While valid=1 and ready=0, idx and onehot are stable for any number of cycles.
- All outputs are registered. There is no combinational path from req, mask or ready to any output.

## Test plan
- Reset, then req=8'b0000_0000 for 5 cycles: valid=0, onehot=0, pending=0, ovf=0 throughout.
- mask=8'hFF, single-cycle req=8'b1001_0011, ready=1: grants in order idx=7, 4, 1, 0, with onehot 8'h80, 8'h10, 8'h02, 8'h01. Each grant is separated by one valid=0 cycle. pending reaches 0 after the fourth accept.
- mask=8'hFF, req=8'b0000_0101 with ready=0 held for 6 cycles: valid=1, idx=2, onehot=8'h04 stay stable. Then pulse req[6] during OFFER: the grant stays at idx=2. After ready=1, the next grant is idx=6, then idx=0.
- mask=8'b0111_1111, req=8'hFF: first grant is idx=6. pending[7] stays 1 and is never granted until mask[7]=1, after which the next IDLE grant is idx=7.
- Pulse req[3] twice while pending[3]=1 and not accepted: ovf=1 and stays 1. Assert ovf_clr and req[3] in the same cycle: ovf remains 1. Assert ovf_clr alone: ovf=0 next cycle.
- In OFFER with idx=5, assert reset for 1 cycle: valid=0, pending=0, idx=0, ovf=0 after that edge. No grant appears afterwards without new req.

Source files
------------

// File: rtl/req_priority_arbiter.sv
// Purpose: latch request pulses into a pending set and offer the highest-index eligible one downstream.
// Latency: req sampled at edge t -> pending after t, valid after t+1; one idle cycle between grants.
// Backpressure: grant (idx/onehot) held stable while valid & ~ready; no preemption during an offer.
module req_priority_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic          ready,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot,
    output logic [N-1:0]  pending,
    output logic          ovf,
    input  logic          ovf_clr
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx_nxt;
    logic [N-1:0]    onehot_nxt;
    logic [N-1:0]    pending_nxt;
    logic            ovf_nxt;

    logic [N-1:0]    elig;
    logic            elig_any;
    logic [IW-1:0]   sel_idx;
    logic [N-1:0]    sel_onehot;
    logic            accept;
    logic [N-1:0]    acc_clr;

    // valid comes straight from the state register, so it is a registered output
    assign valid    = (state == ST_OFFER);
    assign accept   = valid & ready;
    assign acc_clr  = accept ? onehot : '0;

    // eligibility is taken from the registered pending set, never from raw req
    assign elig     = pending & mask;
    assign elig_any = |elig;

    // highest-index eligible requester; later iterations override so bit N-1 wins
    always_comb begin
        sel_idx    = '0;
        sel_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                sel_idx    = IW'(i);
                sel_onehot = N'(1) << i;
            end
        end
    end

    // pending set/clear: a new request on the bit being accepted keeps it set
    always_comb begin
        pending_nxt = (pending & ~acc_clr) | req;
    end

    // sticky overflow: re-request of a bit still pending and not being retired; set beats clear
    always_comb begin
        ovf_nxt = ovf & ~ovf_clr;
        if (|(req & pending & ~acc_clr)) begin
            ovf_nxt = 1'b1;
        end
    end

    // grant FSM: capture a selection in IDLE, hold it untouched through OFFER until accepted
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        onehot_nxt = onehot;
        case (state)
            ST_IDLE: begin
                onehot_nxt = '0;
                if (elig_any) begin
                    state_nxt  = ST_OFFER;
                    idx_nxt    = sel_idx;
                    onehot_nxt = sel_onehot;
                end
            end
            ST_OFFER: begin
                if (ready) begin
                    state_nxt  = ST_IDLE;
                    onehot_nxt = '0;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                onehot_nxt = '0;
            end
        endcase
    end

    // state and output registers; reset drops any offer and all pending bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            onehot  <= '0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            onehot  <= onehot_nxt;
            pending <= pending_nxt;
            ovf     <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_req_priority_arbiter.sv
// Purpose: directed stimulus for req_priority_arbiter with a per-cycle model compare and literal checks.
// Latency: inputs change 1ns after each rising edge; model compare on every falling edge.
// Backpressure: ready is driven directly by the stimulus sequence.
module tb_req_priority_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ready;
    logic       valid;
    logic [2:0] idx;
    logic [7:0] onehot;
    logic [7:0] pending;
    logic       ovf;
    logic       ovf_clr;

    int errors = 0;
    int checks = 0;

    req_priority_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .mask    (mask),
        .ready   (ready),
        .valid   (valid),
        .idx     (idx),
        .onehot  (onehot),
        .pending (pending),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a set of pending requesters and an optional "current offer".
    bit   m_pend [8];
    bit   m_busy;
    int   m_idx;
    bit   m_ovf;
    bit   m_live = 0;

    function automatic logic [7:0] pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 0;
            m_busy = 0;
            m_idx  = 0;
            m_ovf  = 0;
            m_live = 1;
        end else if (m_live) begin
            int  taken;
            int  pick;
            bit  again;
            taken = (m_busy && ready) ? m_idx : -1;
            again = 0;
            for (int i = 0; i < 8; i++)
                if (req[i] && m_pend[i] && i != taken) again = 1;
            m_ovf = again ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
            if (m_busy) begin
                if (ready) m_busy = 0;
            end else begin
                pick = -1;
                for (int i = 7; i >= 0; i--)
                    if (pick < 0 && m_pend[i] && mask[i]) pick = i;
                if (pick >= 0) begin
                    m_busy = 1;
                    m_idx  = pick;
                end
            end
            for (int i = 0; i < 8; i++)
                m_pend[i] = (m_pend[i] && i != taken) || req[i];
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_valid", int'(valid), int'(m_busy));
            chk("model_onehot", int'(onehot), m_busy ? (1 << m_idx) : 0);
            chk("model_pending", int'(pending), int'(pend_vec()));
            chk("model_ovf", int'(ovf), int'(m_ovf));
            if (m_busy) chk("model_idx", int'(idx), m_idx);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_oh [8];

    initial begin
        reset = 1'b1; req = '0; mask = 8'hFF; ready = 1'b0; ovf_clr = 1'b0;
        #1;
        step(); step();
        reset = 1'b0;
        chk("rst_valid", int'(valid), 0);
        chk("rst_onehot", int'(onehot), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_idx", int'(idx), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_valid", int'(valid), 0);
            chk("idle_pending", int'(pending), 0);
        end

        // burst 1001_0011 with ready high: 7,4,1,0 with a bubble between grants
        exp_oh[0] = 8'h80; exp_oh[1] = 8'h00; exp_oh[2] = 8'h10; exp_oh[3] = 8'h00;
        exp_oh[4] = 8'h02; exp_oh[5] = 8'h00; exp_oh[6] = 8'h01; exp_oh[7] = 8'h00;
        ready = 1'b1; req = 8'b1001_0011;
        step();
        req = '0;
        chk("burst_pend", int'(pending), 8'h93);
        chk("burst_v0", int'(valid), 0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("burst_onehot", int'(onehot), int'(exp_oh[k]));
            chk("burst_valid", int'(valid), (k % 2 == 0) ? 1 : 0);
        end
        chk("burst_pend_end", int'(pending), 0);

        // hold under backpressure, no preemption by req[6]
        ready = 1'b0; req = 8'b0000_0101;
        step();
        req = '0;
        step();
        chk("hold_idx", int'(idx), 2);
        chk("hold_oh", int'(onehot), 8'h04);
        for (int k = 0; k < 6; k++) begin
            req = (k == 2) ? 8'h40 : 8'h00;
            step();
            chk("hold_valid", int'(valid), 1);
            chk("hold_idx_k", int'(idx), 2);
        end
        req = '0;
        chk("hold_pend", int'(pending), 8'h45);
        ready = 1'b1;
        step();
        chk("hold_acc_valid", int'(valid), 0);
        chk("hold_acc_pend", int'(pending), 8'h41);
        step();
        chk("next_idx6", int'(idx), 6);
        step();
        step();
        chk("next_idx0", int'(idx), 0);
        step();
        chk("hold_pend_end", int'(pending), 0);

        // masked bit 7 stays pending until unmasked
        mask = 8'b0111_1111; req = 8'hFF;
        step();
        req = '0;
        step();
        chk("mask_first", int'(idx), 6);
        for (int k = 0; k < 16; k++) step();
        chk("mask_valid", int'(valid), 0);
        chk("mask_pend", int'(pending), 8'h80);
        mask = 8'hFF;
        step();
        chk("unmask_valid", int'(valid), 1);
        chk("unmask_idx", int'(idx), 7);
        step();
        chk("unmask_pend", int'(pending), 0);

        // overflow: set, sticky, set-beats-clear, clear
        ready = 1'b0; req = 8'h08;
        step();
        req = '0;
        step();
        chk("ovf_offer", int'(idx), 3);
        req = 8'h08;
        step();
        chk("ovf_set", int'(ovf), 1);
        req = '0;
        step();
        chk("ovf_sticky", int'(ovf), 1);
        req = 8'h08; ovf_clr = 1'b1;
        step();
        chk("ovf_setwins", int'(ovf), 1);
        req = '0;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);
        // re-request on the bit being accepted: stays pending, not an overflow
        ready = 1'b1; req = 8'h08;
        step();
        req = '0;
        chk("acc_req_pend", int'(pending), 8'h08);
        chk("acc_req_ovf", int'(ovf), 0);
        step();
        chk("acc_req_regrant", int'(idx), 3);
        step();
        chk("acc_req_pend0", int'(pending), 0);

        // reset during an offer of idx 5 with ovf set
        ready = 1'b0; req = 8'h20;
        step();
        req = '0;
        step();
        chk("pre_rst_idx", int'(idx), 5);
        req = 8'h20;
        step();
        req = '0;
        chk("pre_rst_ovf", int'(ovf), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_pend", int'(pending), 0);
        chk("mid_rst_idx", int'(idx), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        chk("mid_rst_oh", int'(onehot), 0);
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_valid", int'(valid), 0);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
